// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared defaults and FSM state encoding for the systolic array input feeder.
//   DEF_DATA_W     : width of one MAC lane operand
//   DEF_N_MAC      : number of MAC columns (lanes)
//   DEF_FIFO_DEPTH : input vector buffer depth (power of two, >= 2)
//   feeder_state_t : IDLE / RUN / DRAIN
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_N_MAC      = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Synchronous FIFO with registered occupancy count. Data written on an edge
// only becomes visible on rd_data after that edge (no fall-through).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, wr_data   : write request and data (ignored when full)
//   pop             : read request (ignored when empty), rd_data is head entry
//   count           : number of stored entries
//   full, empty     : occupancy flags derived from count
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// -----------------------------------------------------------------------------
// systolic_input_feeder
// Buffers operand vectors, issues one per cycle while not held, and skews lane
// k by k cycles so it lines up with the valid pipeline of MAC column k.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | nothing buffered or in flight
//   ST_RUN   | vectors buffered and/or being issued
//   ST_DRAIN | buffer empty, waiting for the last vector to reach MAC N_MAC-1
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream vector handshake, in_data carries N_MAC lanes
//   hold                : downstream stall, blocks issue only
//   start               : one-cycle pulse per issued vector
//   mac_din             : skewed operands, lane k to MAC k
//   busy, done          : activity flag and end-of-drain pulse
//   fifo_level          : buffered vector count
// -----------------------------------------------------------------------------
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int N_MAC      = DEF_N_MAC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_MAC*DATA_W-1:0]       in_data,
  input  logic                          hold,
  output logic                          start,
  output logic [N_MAC*DATA_W-1:0]       mac_din,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int VW    = N_MAC * DATA_W;
  localparam int CNT_W = $clog2(N_MAC + 1);

  feeder_state_t    state;
  logic             push;
  logic             pop;
  logic [VW-1:0]    fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [VW-1:0]    iss_data;
  logic [CNT_W-1:0] drain_cnt;
  // vld[i] is start delayed by i+1 cycles; it qualifies lane i+1's capture.
  logic [N_MAC-2:0] vld;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && !hold;
  assign busy     = (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .count   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      start     <= 1'b0;
      iss_data  <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      start <= pop;
      done  <= 1'b0;
      if (pop) iss_data <= fifo_rd;

      if (pop)                   drain_cnt <= CNT_W'(N_MAC);
      else if (drain_cnt != '0)  drain_cnt <= drain_cnt - CNT_W'(1);

      case (state)
        ST_IDLE:  if (push) state <= ST_RUN;
        ST_RUN:   if (fifo_empty && !push) state <= ST_DRAIN;
        ST_DRAIN: begin
          // A new push cancels the drain; done stays in DRAIN for its pulse
          // cycle so busy covers it, then the FSM drops to IDLE.
          if (push)                 state <= ST_RUN;
          else if (done)            state <= ST_IDLE;
          else if (drain_cnt == '0) done  <= 1'b1;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= start;
      for (int i = 1; i < N_MAC - 1; i++) vld[i] <= vld[i-1];
    end
  end

  // Lane k carries a k-deep delay line behind the issue register; the output
  // register only loads when a valid vector arrives so it holds between vectors.
  for (genvar k = 0; k < N_MAC; k++) begin : g_lane
    logic [DATA_W-1:0] lane_q;

    if (k == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst)        lane_q <= '0;
        else if (start) lane_q <= iss_data[0 +: DATA_W];
      end
    end else begin : g_skew
      logic [DATA_W-1:0] pipe [k];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) pipe[i] <= '0;
          lane_q <= '0;
        end else begin
          pipe[0] <= iss_data[k*DATA_W +: DATA_W];
          for (int i = 1; i < k; i++) pipe[i] <= pipe[i-1];
          if (vld[k-1]) lane_q <= pipe[k-1];
        end
      end
    end

    assign mac_din[k*DATA_W +: DATA_W] = lane_q;
  end

endmodule

// File: doc/systolic_input_feeder.md
SYSTOLIC_INPUT_FEEDER -- requirements
Module: systolic_input_feeder

Interface
REQ-001 Parameter DATA_W, default 8, bit width of one MAC lane operand.
REQ-002 Parameter N_MAC, default 4, number of MAC columns (lanes).
REQ-003 Parameter FIFO_DEPTH, default 4, input vector buffer depth (power of two, >=2).
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers one operand vector.
REQ-007 in_ready  output  1  feeder can accept a vector this cycle.
REQ-008 in_data  input  N_MAC*DATA_W  operand vector; lane k = bits [k*DATA_W +: DATA_W].
REQ-009 hold  input  1  downstream stall; blocks issue while high.
REQ-010 start  output  1  one-cycle issue pulse into the valid pipeline controller.
REQ-011 mac_din  output  N_MAC*DATA_W  skewed operands, lane k to MAC k.
REQ-012 busy  output  1  vectors buffered or in flight.
REQ-013 done  output  1  one-cycle pulse when the last in-flight vector has reached MAC N_MAC-1.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH)+1  current buffered vector count.

Function
REQ-015 Push on a cycle with in_valid && in_ready; in_ready SHALL equal (fifo_level < FIFO_DEPTH) && !rst, combinational from registered count.
REQ-016 A pushed vector SHALL be eligible for issue no earlier than the following cycle (no fall-through).
REQ-017 Issue condition at an edge: FIFO non-empty && !hold; that edge pops one vector and sets start=1 for exactly the next cycle S.
REQ-018 Back-to-back issue SHALL be allowed: start may stay high on consecutive cycles, one vector per cycle.
REQ-019 Simultaneous push and pop SHALL leave fifo_level unchanged; push when full is not accepted (in_ready=0).
REQ-020 Lane k of the vector issued in cycle S SHALL appear on mac_din lane k during cycle S+1+k, aligned with valid_ctrl[k] of the controller.
REQ-021 mac_din lanes SHALL hold their last value between vectors; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 FSM states: IDLE, RUN, DRAIN.
REQ-023 IDLE -> RUN on first push; RUN -> DRAIN when FIFO empties with no push pending; DRAIN -> RUN on a push; DRAIN -> IDLE when the drain counter expires.
REQ-024 Drain counter SHALL load N_MAC on every issue and decrement each cycle to zero; for the last vector issued in cycle S, done SHALL pulse in cycle S+N_MAC+1 if no further issue occurred.
REQ-025 busy SHALL be 1 in every state except IDLE, i.e. from the cycle after the first push until the cycle of the done pulse inclusive.
REQ-026 hold SHALL NOT block pushes, in-flight skew shifting or the drain counter.

Reset
REQ-027 While rst is high: FIFO empty, fifo_level=0, in_ready=0, start=0, mac_din all zero, busy=0, done=0, state IDLE, drain counter 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight vectors without emitting start or done; in_ready=1 in the first cycle after release.

Structure
REQ-029 N_MAC, DATA_W, FIFO_DEPTH defaults and the FSM state enumeration SHALL live in shared package systolic_pkg.
REQ-030 Buffer SHALL be a sub-module sync_fifo (synchronous, registered count, no fall-through); skew lines and FSM in the top.

Verification
REQ-031 Single vector 0x04030201 pushed at cycle 0, hold=0 -> start in cycle 2; mac_din lanes 0..3 = 01,02,03,04 in cycles 3,4,5,6; done in cycle 7; busy cycles 1-7.
REQ-032 Push 5 vectors back-to-back with hold=1 -> in_ready low after 4 accepted, fifo_level=4; release hold -> 4 consecutive start pulses then the 5th issued, order preserved.
REQ-033 Stream 8 vectors continuously with hold=0 -> start high 8 consecutive cycles, fifo_level never exceeds 2, single done after the last.
REQ-034 hold toggled 1-0-1 during issue -> no start while hold=1 on the issuing edge, in-flight lanes still advance each cycle.
REQ-035 Assert rst for 1 cycle with 3 vectors buffered and 2 in flight -> no further start or done, fifo_level=0, mac_din zero, in_ready=1 the cycle after release.
REQ-036 Push arriving in DRAIN (2 cycles before expiry) -> no done pulse, state returns to RUN, done after the new vector completes.
